axi_ram_ctrl: RTL and testbench
===============================

Name: axi_ram_ctrl

Overview:
- AXI4 slave (responder) that turns AXI read/write bursts into accesses on one port of the team's byte-enabled RAM.
- Drives the RAM port's address, write data, byte-enable and write-enable signals, and consumes its registered read data (1-cycle read latency).
- Sits between a NoC endpoint and the RAM.
- One transaction in flight at a time; reads and writes are arbitrated round-robin.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI byte-address width
- ADDR_WIDTH, 16, RAM word-address width
- BYTE_WIDTH, 8, bits per byte lane
- BATCH_WIDTH, 4, byte lanes per word (data width DW = BYTE_WIDTH*BATCH_WIDTH)
- ID_WIDTH, 4, AXI ID width

Ports:
- clk in 1: single clock, rising edge
- rst_n in 1: asynchronous active-low reset
- awid/awaddr/awlen/awsize/awburst in ID_WIDTH/AXI_ADDR_WIDTH/8/3/2: write address
- awvalid in 1, awready out 1: AW handshake
- wdata in DW, wstrb in BATCH_WIDTH, wlast in 1: write data
- wvalid in 1, wready out 1: W handshake
- bid out ID_WIDTH, bresp out 2: write response
- bvalid out 1, bready in 1: B handshake
- arid/araddr/arlen/arsize/arburst in ID_WIDTH/AXI_ADDR_WIDTH/8/3/2: read address
- arvalid in 1, arready out 1: AR handshake
- rid out ID_WIDTH, rdata out DW, rresp out 2, rlast out 1: read data
- rvalid out 1, rready in 1: R handshake
- ram_addr out ADDR_WIDTH: RAM word address
- ram_wdata out DW: RAM write data
- ram_byte_en out BATCH_WIDTH: RAM byte enables
- ram_write_en out 1: RAM write strobe
- ram_rdata in DW: RAM registered read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; awready, wready, bvalid, arready, rvalid, rlast, ram_write_en = 0; bresp, rresp, rdata = 0; priority bit = write. Reset mid-burst drops the burst silently; no response is issued.
- Word address = axaddr[log2(BATCH_WIDTH) +: ADDR_WIDTH]; higher bits are ignored. axsize is ignored; each beat is one full word.
- States: IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_CAP, RD_DATA.
- IDLE: awready = awvalid && (!arvalid || prio==W); arready = arvalid && (!awvalid || prio==R). This is combinational and depends only on state and valids.
  - Both valids high: the priority holder wins, and the priority bit toggles after every grant.
  - On handshake, latch id, word address, len and burst; clear beat counter and error flag.
- WR_DATA: wready = 1.
  - On each W handshake the same cycle drives ram_write_en=1, ram_addr=cur, ram_wdata=wdata, ram_byte_en=wstrb.
  - INCR advances cur by 1, wrapping modulo 2**ADDR_WIDTH. FIXED holds cur.
  - WRAP or reserved burst: beats are accepted, ram_write_en is held 0, and the error flag is set.
  - wlast != (beat==len) on any beat sets the error flag.
  - After beat len (len+1 beats total): go to WR_RESP. Beat count is governed by awlen, not wlast.
- WR_RESP: bvalid=1, bid=latched id, bresp = error ? SLVERR(2) : OKAY(0). Held until bready, then IDLE; bvalid drops on the next cycle.
- RD_ADDR: ram_addr=cur, ram_write_en=0; go to RD_CAP next cycle.
- RD_CAP: at the clock edge, rdata <= ram_rdata, rvalid <= 1, rlast <= (beat==len), rid/rresp set; go to RD_DATA.
  - rvalid first rises 2 edges after the AR handshake edge.
- RD_DATA: rdata, rid, rresp, rlast are held stable while rvalid && !rready.
  - On handshake: rvalid <= 0. If last, go IDLE. Else advance cur (INCR wraps, FIXED holds), increment beat, go RD_ADDR.
  - Sustained throughput is 1 beat per 3 cycles.
- Read with WRAP or reserved burst: all len+1 beats are returned with rresp=SLVERR and rdata=0; the RAM is not read.
- ram_write_en = 0 in every state except a WR_DATA handshake cycle; ram_byte_en = 0 when not writing.
- awlen=0 / arlen=0: single beat, with wlast/rlast set on that beat.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10)
  - burst constants (FIXED=0, INCR=1, WRAP=2)
  - localparam for the byte-offset width, log2(BATCH_WIDTH)
- No sub-module; burst address and beat tracking is a single shared counter inside the block.

Test Plan:
- Single write: awaddr=0x10, awlen=0, INCR, wdata=0xDEADBEEF, wstrb=4'b0011 -> ram_write_en pulses once with ram_addr=4, ram_byte_en=0011; bresp=OKAY with bid echoed.
- INCR read burst after preloading words 4..7 with 1..4: araddr=0x10, arlen=3 -> rdata 1,2,3,4 with rlast only on beat 4, rresp=OKAY. Hold rready=0 for 5 cycles mid-burst -> rdata stable throughout.
- Simultaneous AW and AR from reset: write granted first. Next simultaneous request: read granted first.
- Protocol errors:
  - awburst=WRAP, awlen=1 -> two beats accepted, no RAM write, bresp=SLVERR.
  - INCR awlen=2 with wlast asserted on beat 1 -> bresp=SLVERR.
- Address wrap: awaddr word 0xFFFF, awlen=1, INCR -> writes land at RAM addresses 0xFFFF then 0x0000.
- Reset: assert rst_n=0 mid read burst -> rvalid=0 immediately, state IDLE; a subsequent write completes normally.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the AXI-to-RAM bridge.
// FSM encodings, AXI response/burst codes and address helpers.
package ram_ctrl_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_CAP  = 3'd4;
    localparam logic [2:0] S_RD_DATA = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam int BATCH_DEF = 4;
    localparam int OFF_W     = $clog2(BATCH_DEF);

    function automatic int off_width(input int batch);
        return $clog2(batch);
    endfunction

endpackage

// File: rtl/axi_ram_if.sv
// AXI4 bus bundle between the NoC endpoint (master)
// and the RAM controller (slave).
interface axi_ram_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 4,
    parameter int DW             = 32,
    parameter int BATCH_WIDTH    = 4
);
    logic [ID_WIDTH-1:0]       awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [DW-1:0]             wdata;
    logic [BATCH_WIDTH-1:0]    wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [ID_WIDTH-1:0]       arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;

    logic [ID_WIDTH-1:0]       rid;
    logic [DW-1:0]             rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_ram_ctrl.sv
// AXI4 slave serving one burst at a time from a byte-enabled RAM port
// with 1-cycle registered read data; reads/writes share round-robin.
module axi_ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int BATCH_WIDTH    = 4,
    parameter int ID_WIDTH       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    axi_ram_if.slave                         axi,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [BYTE_WIDTH*BATCH_WIDTH-1:0] ram_wdata,
    output logic [BATCH_WIDTH-1:0]           ram_byte_en,
    output logic                             ram_write_en,
    input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0] ram_rdata
);

    localparam int OFF_BITS = off_width(BATCH_WIDTH);

    logic [2:0]            state;
    logic                  prio;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] nxt;
    logic [7:0]            len_q;
    logic [7:0]            beat;
    logic [1:0]            burst_q;
    logic                  err;

    logic idle, aw_gnt, ar_gnt, w_hs, last, burst_ok;
    logic unused;

    assign unused = ^{axi.awsize, axi.arsize,
                      axi.awaddr, axi.araddr};

    assign idle   = state == S_IDLE;
    // prio low means the write channel wins a tie
    assign aw_gnt = idle && axi.awvalid
                    && (!axi.arvalid || !prio);
    assign ar_gnt = idle && axi.arvalid
                    && (!axi.awvalid || prio);

    assign axi.awready = aw_gnt;
    assign axi.arready = ar_gnt;
    assign axi.wready  = state == S_WR_DATA;
    assign w_hs        = axi.wready && axi.wvalid;

    assign last     = beat == len_q;
    assign burst_ok = (burst_q == BURST_FIXED)
                   || (burst_q == BURST_INCR);
    assign nxt      = (burst_q == BURST_INCR)
                    ? cur + ADDR_WIDTH'(1) : cur;

    assign axi.bvalid = state == S_WR_RESP;
    assign axi.bid    = id_q;
    assign axi.bresp  = (axi.bvalid && err)
                      ? RESP_SLVERR : RESP_OKAY;

    assign ram_addr     = cur;
    assign ram_wdata    = axi.wdata;
    assign ram_write_en = w_hs && burst_ok;
    assign ram_byte_en  = ram_write_en ? axi.wstrb : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            id_q       <= '0;
            cur        <= '0;
            len_q      <= '0;
            beat       <= '0;
            burst_q    <= '0;
            err        <= 1'b0;
            axi.rvalid <= 1'b0;
            axi.rlast  <= 1'b0;
            axi.rdata  <= '0;
            axi.rresp  <= RESP_OKAY;
            axi.rid    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (aw_gnt || ar_gnt) begin
                        prio    <= ~prio;
                        beat    <= '0;
                        err     <= 1'b0;
                        id_q    <= aw_gnt ? axi.awid : axi.arid;
                        len_q   <= aw_gnt ? axi.awlen : axi.arlen;
                        burst_q <= aw_gnt ? axi.awburst
                                          : axi.arburst;
                        cur     <= aw_gnt
                            ? axi.awaddr[OFF_BITS +: ADDR_WIDTH]
                            : axi.araddr[OFF_BITS +: ADDR_WIDTH];
                        state   <= aw_gnt ? S_WR_DATA : S_RD_ADDR;
                    end
                end
                S_WR_DATA: begin
                    if (w_hs) begin
                        if (!burst_ok || (axi.wlast != last))
                            err <= 1'b1;
                        cur  <= nxt;
                        beat <= beat + 8'd1;
                        if (last)
                            state <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi.bready)
                        state <= S_IDLE;
                end
                S_RD_ADDR: state <= S_RD_CAP;
                S_RD_CAP: begin
                    axi.rdata  <= burst_ok ? ram_rdata : '0;
                    axi.rresp  <= burst_ok ? RESP_OKAY
                                           : RESP_SLVERR;
                    axi.rvalid <= 1'b1;
                    axi.rlast  <= last;
                    axi.rid    <= id_q;
                    state      <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (axi.rready) begin
                        axi.rvalid <= 1'b0;
                        if (last) begin
                            state <= S_IDLE;
                        end else begin
                            cur   <= nxt;
                            beat  <= beat + 8'd1;
                            state <= S_RD_ADDR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// Scoreboard bench for axi_ram_ctrl with a behavioural
// byte-enabled RAM (1-cycle registered read).
module tb_axi_ram_ctrl;
    import ram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ram_if #(.AXI_ADDR_WIDTH(32), .ID_WIDTH(4),
                 .DW(32), .BATCH_WIDTH(4)) axi();

    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_byte_en;
    logic        ram_write_en;

    axi_ram_ctrl #(
        .AXI_ADDR_WIDTH(32), .ADDR_WIDTH(16), .BYTE_WIDTH(8),
        .BATCH_WIDTH(4), .ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .axi(axi),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_byte_en(ram_byte_en), .ram_write_en(ram_write_en),
        .ram_rdata(ram_rdata)
    );

    bit [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_write_en)
            for (int i = 0; i < 4; i++)
                if (ram_byte_en[i])
                    mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
        ram_rdata <= mem[ram_addr];
    end

    typedef struct packed {
        logic [15:0] addr; logic [31:0] data; logic [3:0] be;
    } w_t;
    typedef struct packed {
        logic [3:0] id; logic [1:0] resp;
    } b_t;
    typedef struct packed {
        logic [3:0] id; logic [31:0] data;
        logic [1:0] resp; logic last;
    } r_t;

    w_t wq[$];
    b_t bq[$];
    r_t rq[$];
    int tests = 0;
    int fails = 0;
    int r_pops = 0;

    task automatic chk(input logic ok, input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the queues
    initial begin
        w_t we, wa;
        b_t bx, ba;
        r_t rx, ra, r_hold;
        logic stalled;
        stalled = 1'b0;
        r_hold = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                wa = '{ram_addr, ram_wdata, ram_byte_en};
                if (ram_write_en) begin
                    if (wq.size() == 0) begin
                        chk(1'b0, "ram_wr_unexpected", 64'(wa), 64'(0));
                    end else begin
                        we = wq.pop_front();
                        chk(wa == we, "ram_wr", 64'(wa), 64'(we));
                    end
                end else begin
                    chk(ram_byte_en == 4'd0, "byte_en_idle",
                        64'(ram_byte_en), 64'(0));
                end
                ba = '{axi.bid, axi.bresp};
                if (axi.bvalid && axi.bready) begin
                    if (bq.size() == 0) begin
                        chk(1'b0, "b_unexpected", 64'(ba), 64'(0));
                    end else begin
                        bx = bq.pop_front();
                        chk(ba == bx, "b_resp", 64'(ba), 64'(bx));
                    end
                end
                ra = '{axi.rid, axi.rdata, axi.rresp, axi.rlast};
                if (axi.rvalid) begin
                    if (stalled)
                        chk(ra == r_hold, "r_stable",
                            64'(ra), 64'(r_hold));
                    if (axi.rready) begin
                        r_pops++;
                        if (rq.size() == 0) begin
                            chk(1'b0, "r_unexpected", 64'(ra), 64'(0));
                        end else begin
                            rx = rq.pop_front();
                            chk(ra == rx, "r_beat", 64'(ra), 64'(rx));
                        end
                    end
                    r_hold = ra;
                    stalled = !axi.rready;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic exp_w(input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        wq.push_back('{a, d, be});
    endtask

    task automatic exp_b(input logic [3:0] id, input logic [1:0] r);
        bq.push_back('{id, r});
    endtask

    task automatic exp_r(input logic [3:0] id, input logic [31:0] d,
                         input logic [1:0] r, input logic l);
        rq.push_back('{id, d, r, l});
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [1:0] b);
        axi.awid = id; axi.awaddr = a; axi.awlen = len;
        axi.awsize = 3'd2; axi.awburst = b; axi.awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [1:0] b);
        axi.arid = id; axi.araddr = a; axi.arlen = len;
        axi.arsize = 3'd2; axi.arburst = b; axi.arvalid = 1'b1;
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!axi.awready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(axi.awready, "aw_handshake", 64'(axi.awready), 64'(1));
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
    endtask

    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!axi.arready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(axi.arready, "ar_handshake", 64'(axi.arready), 64'(1));
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input logic l);
        int n = 0;
        axi.wdata = d; axi.wstrb = s; axi.wlast = l;
        axi.wvalid = 1'b1;
        @(negedge clk);
        while (!axi.wready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(axi.wready, "w_handshake", 64'(axi.wready), 64'(1));
        @(posedge clk);
        #1 axi.wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() + bq.size() + rq.size()) != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk(n < 500, "drain_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v0, v1, v2;
        int base, n;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0;
        axi.awsize = '0; axi.awburst = '0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
        axi.arsize = '0; axi.arburst = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready = 1'b1; axi.rready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk({axi.awready, axi.wready, axi.bvalid, axi.arready,
             axi.rvalid, axi.rlast, ram_write_en} == 7'd0,
            "reset_ctrl",
            64'({axi.awready, axi.wready, axi.bvalid, axi.arready,
                 axi.rvalid, axi.rlast, ram_write_en}), 64'(0));
        chk({axi.bresp, axi.rresp, axi.rdata} == 36'd0, "reset_data",
            64'({axi.bresp, axi.rresp, axi.rdata}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie from reset: write wins, then the read runs
        exp_w(16'h0010, 32'h1111_1111, 4'hF);
        exp_b(4'd1, RESP_OKAY);
        exp_r(4'd2, 32'h1111_1111, RESP_OKAY, 1'b1);
        set_aw(4'd1, 32'h40, 8'd0, BURST_INCR);
        set_ar(4'd2, 32'h40, 8'd0, BURST_INCR);
        @(negedge clk);
        chk(axi.awready && !axi.arready, "arb_write_first",
            64'({axi.awready, axi.arready}), 64'(2'b10));
        @(posedge clk);
        #1 axi.awvalid = 1'b0;
        fork
            send_w(32'h1111_1111, 4'hF, 1'b1);
            wait_ar();
        join
        wait_idle();

        // Single partial-strobe write
        exp_w(16'h0004, 32'hDEAD_BEEF, 4'b0011);
        exp_b(4'd3, RESP_OKAY);
        set_aw(4'd3, 32'h10, 8'd0, BURST_INCR);
        wait_aw();
        send_w(32'hDEAD_BEEF, 4'b0011, 1'b1);
        wait_idle();

        // Next tie: read holds priority, sees the old word
        exp_r(4'd5, 32'h1111_1111, RESP_OKAY, 1'b1);
        exp_w(16'h0010, 32'h2222_2222, 4'hF);
        exp_b(4'd6, RESP_OKAY);
        set_aw(4'd6, 32'h40, 8'd0, BURST_INCR);
        set_ar(4'd5, 32'h40, 8'd0, BURST_INCR);
        @(negedge clk);
        chk(axi.arready && !axi.awready, "arb_read_first",
            64'({axi.awready, axi.arready}), 64'(2'b01));
        @(posedge clk);
        #1 axi.arvalid = 1'b0;
        begin
            wait_aw();
            send_w(32'h2222_2222, 4'hF, 1'b1);
        end
        wait_idle();

        // Preload words 4..7 with 1..4
        for (int i = 0; i < 4; i++)
            exp_w(16'(4 + i), 32'(i + 1), 4'hF);
        exp_b(4'd7, RESP_OKAY);
        set_aw(4'd7, 32'h10, 8'd3, BURST_INCR);
        wait_aw();
        for (int i = 0; i < 4; i++)
            send_w(32'(i + 1), 4'hF, i == 3);
        wait_idle();

        // INCR read burst with latency check and a mid-burst stall
        for (int i = 0; i < 4; i++)
            exp_r(4'd5, 32'(i + 1), RESP_OKAY, i == 3);
        base = r_pops;
        set_ar(4'd5, 32'h10, 8'd3, BURST_INCR);
        wait_ar();
        @(negedge clk) v0 = axi.rvalid;
        @(negedge clk) v1 = axi.rvalid;
        @(negedge clk) v2 = axi.rvalid;
        chk({v0, v1, v2} == 3'b001, "rd_latency",
            64'({v0, v1, v2}), 64'(3'b001));
        n = 0;
        while (r_pops < base + 1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 axi.rready = 1'b0;
        repeat (5) @(posedge clk);
        #1 axi.rready = 1'b1;
        wait_idle();

        // WRAP write: beats accepted, RAM untouched
        exp_b(4'd6, RESP_SLVERR);
        set_aw(4'd6, 32'h80, 8'd1, BURST_WRAP);
        wait_aw();
        send_w(32'hBAD0_0000, 4'hF, 1'b0);
        send_w(32'hBAD0_0001, 4'hF, 1'b1);
        wait_idle();

        // Early wlast: data still written, response flags it
        for (int i = 0; i < 3; i++)
            exp_w(16'(16'h24 + i), 32'(32'hA0 + i), 4'hF);
        exp_b(4'd10, RESP_SLVERR);
        set_aw(4'd10, 32'h90, 8'd2, BURST_INCR);
        wait_aw();
        send_w(32'hA0, 4'hF, 1'b1);
        send_w(32'hA1, 4'hF, 1'b0);
        send_w(32'hA2, 4'hF, 1'b1);
        wait_idle();

        // WRAP read returns zeroed SLVERR beats
        exp_r(4'd2, 32'h0, RESP_SLVERR, 1'b0);
        exp_r(4'd2, 32'h0, RESP_SLVERR, 1'b1);
        set_ar(4'd2, 32'h10, 8'd1, BURST_WRAP);
        wait_ar();
        wait_idle();

        // Word address wraps from 0xFFFF to 0x0000
        exp_w(16'hFFFF, 32'hA5A5_A5A5, 4'hF);
        exp_w(16'h0000, 32'h5A5A_5A5A, 4'hF);
        exp_b(4'd4, RESP_OKAY);
        set_aw(4'd4, 32'h0003_FFFC, 8'd1, BURST_INCR);
        wait_aw();
        send_w(32'hA5A5_A5A5, 4'hF, 1'b0);
        send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
        wait_idle();

        // FIXED read of word 0; upper address bits are ignored
        exp_r(4'd8, 32'h5A5A_5A5A, RESP_OKAY, 1'b0);
        exp_r(4'd8, 32'h5A5A_5A5A, RESP_OKAY, 1'b1);
        set_ar(4'd8, 32'h8004_0000, 8'd1, BURST_FIXED);
        wait_ar();
        wait_idle();

        // Reset in the middle of a stalled read burst
        axi.rready = 1'b0;
        set_ar(4'd11, 32'h10, 8'd3, BURST_INCR);
        wait_ar();
        n = 0;
        while (!axi.rvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(axi.rvalid, "rst_pre_rvalid", 64'(axi.rvalid), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(!axi.rvalid && !axi.rlast, "rst_rvalid",
            64'({axi.rvalid, axi.rlast}), 64'(0));
        chk(dut.state == S_IDLE, "rst_state",
            64'(dut.state), 64'(S_IDLE));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        axi.rready = 1'b1;

        exp_w(16'h000C, 32'hCAFE_F00D, 4'hF);
        exp_b(4'd9, RESP_OKAY);
        set_aw(4'd9, 32'h30, 8'd0, BURST_INCR);
        wait_aw();
        send_w(32'hCAFE_F00D, 4'hF, 1'b1);
        wait_idle();

        repeat (4) @(negedge clk);
        chk((wq.size() + bq.size() + rq.size()) == 0, "queues_empty",
            64'(wq.size() + bq.size() + rq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
